jtag_burst_chain: RTL and testbench

Parametrised JTAG user-chain (JCE1) command/data register that bridges host-shifted JTAG words to the ping-pong buffer and DMA engine. Supports configurable data/address widths and buffer depth, full write bursts, and an optional read-back burst path. It exposes a status word for capture and visual debug, and replaces the fixed 36-bit single-direction chain.

---
 rtl/jtag_burst_pkg.sv | 43 ++++
 rtl/jtag_burst_shifter.sv | 43 ++++
 rtl/jtag_burst_chain.sv | 271 +++++++++++++++++++++++++++
 tb/tb_jtag_burst_chain.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_burst_pkg.sv
// Shared constants for the JTAG burst chain: command codes, FSM states
// and status bit positions. R_* states exist only with JTAG_BURST_READ_EN.
package jtag_burst_pkg;

    localparam logic [3:0] C_SET_ADDR  = 4'h1;
    localparam logic [3:0] C_SET_BE    = 4'h2;
    localparam logic [3:0] C_SET_BURST = 4'h3;
    localparam logic [3:0] C_SEL_ADDR  = 4'h4;
    localparam logic [3:0] C_SEL_BE    = 4'h5;
    localparam logic [3:0] C_SEL_BURST = 4'h6;
    localparam logic [3:0] C_SEL_RD    = 4'h7;
    localparam logic [3:0] C_PUSH      = 4'h8;
    localparam logic [3:0] C_START_RD  = 4'h9;
    localparam logic [3:0] C_POP       = 4'hA;
    localparam logic [3:0] C_SOFT_RST  = 4'hF;

    localparam int ST_ADDR    = 0;
    localparam int ST_BE      = 1;
    localparam int ST_BURST   = 2;
    localparam int ST_WBUSY   = 3;
    localparam int ST_RBUSY   = 4;
    localparam int ST_RVALID  = 5;
    localparam int ST_DROP    = 6;
    localparam int ST_ILLEGAL = 7;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_W_FILL    = 4'd1,
        S_W_WAIT_SW = 4'd2,
        S_W_SWITCH  = 4'd3,
        S_W_LAUNCH  = 4'd4
`ifdef JTAG_BURST_READ_EN
        ,
        S_R_LAUNCH  = 4'd5,
        S_R_WAIT_SW = 4'd6,
        S_R_SWITCH  = 4'd7,
        S_R_ASK     = 4'd8,
        S_R_STORE   = 4'd9,
        S_R_READY   = 4'd10
`endif
    } state_e;

endpackage

// File: rtl/jtag_burst_shifter.sv
// JTAG data register for the JCE1 chain: capture, shift and a registered
// update strobe with a snapshot of the shifted word.
module jtag_burst_shifter
    import jtag_burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic                    JTCK,
    input  logic                    n_reset,
    input  logic                    JTDI,
    input  logic                    JSHIFT,
    input  logic                    JUPDATE,
    input  logic                    JCE1,
    input  logic [DATA_W-1:0]       shadow,
    output logic                    JTD1,
    output logic                    upd_q,
    output logic [DATA_W+CMD_W-1:0] snap
);

    localparam int SW = DATA_W + CMD_W;

    logic [SW-1:0] shift_reg;

    assign JTD1 = shift_reg[0];

    always_ff @(posedge JTCK) begin
        if (!n_reset) begin
            shift_reg <= '0;
            upd_q     <= 1'b0;
            snap      <= '0;
        end else begin
            if (JCE1 && JSHIFT)
                shift_reg <= {JTDI, shift_reg[SW-1:1]};
            else if (JCE1)
                shift_reg <= {{CMD_W{1'b0}}, shadow};
            upd_q <= JUPDATE;
            if (JUPDATE)
                snap <= shift_reg;
        end
    end

endmodule

// File: rtl/jtag_burst_chain.sv
// JCE1 command/data chain bridging JTAG words to ping-pong buffer and DMA.
// Define JTAG_BURST_READ_EN to build the read-back burst path.
module jtag_burst_chain
    import jtag_burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int BUF_AW = 8,
    parameter int STAT_W = 8
) (
    input  logic              JTCK,
    input  logic              n_reset,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE1,
    output logic              JTD1,
    output logic [BUF_AW:0]   pp_address,
    output logic              pp_write_enable,
    output logic [DATA_W-1:0] pp_data_in,
    input  logic [DATA_W-1:0] pp_data_out,
    output logic              pp_switch,
    output logic [DATA_W-1:0] dma_address,
    output logic [3:0]        dma_byte_enable,
    output logic              dma_data_ready,
    output logic              dma_read_ready,
    input  logic              switch_ready,
    output logic [STAT_W-1:0] status_out
);

    localparam int SW = DATA_W + CMD_W;
    localparam int NW = BUF_AW + 1;
    localparam logic [NW-1:0] DEPTH = NW'(2 ** BUF_AW);

    logic              upd_q;
    logic [SW-1:0]     snap;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] payload;
    logic [NW-1:0]     burst_val;

    state_e            state;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] push_q;
    logic [DATA_W-1:0] shadow;
    logic [3:0]        be_q;
    logic [NW-1:0]     burst_n;
    logic [NW-1:0]     wr_idx;
    logic [NW-1:0]     wr_next;
    logic [7:0]        st;
`ifdef JTAG_BURST_READ_EN
    logic [NW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
`else
    logic              unused_rd;
    assign unused_rd = ^pp_data_out;
`endif

    logic is_set_addr, is_set_be, is_set_burst;
    logic is_sel_addr, is_sel_be, is_sel_burst, is_sel_rd;
    logic is_push, is_start, is_pop, is_soft, is_other;
    logic busy, burst_bad, push_ok;

    jtag_burst_shifter #(
        .DATA_W (DATA_W),
        .CMD_W  (CMD_W)
    ) u_shifter (
        .JTCK    (JTCK),
        .n_reset (n_reset),
        .JTDI    (JTDI),
        .JSHIFT  (JSHIFT),
        .JUPDATE (JUPDATE),
        .JCE1    (JCE1),
        .shadow  (shadow),
        .JTD1    (JTD1),
        .upd_q   (upd_q),
        .snap    (snap)
    );

    assign cmd       = snap[CMD_W-1:0];
    assign payload   = snap[SW-1:CMD_W];
    assign burst_val = payload[BUF_AW:0];

    assign is_set_addr  = upd_q && (cmd == CMD_W'(C_SET_ADDR));
    assign is_set_be    = upd_q && (cmd == CMD_W'(C_SET_BE));
    assign is_set_burst = upd_q && (cmd == CMD_W'(C_SET_BURST));
    assign is_sel_addr  = upd_q && (cmd == CMD_W'(C_SEL_ADDR));
    assign is_sel_be    = upd_q && (cmd == CMD_W'(C_SEL_BE));
    assign is_sel_burst = upd_q && (cmd == CMD_W'(C_SEL_BURST));
    assign is_sel_rd    = upd_q && (cmd == CMD_W'(C_SEL_RD));
    assign is_push      = upd_q && (cmd == CMD_W'(C_PUSH));
    assign is_start     = upd_q && (cmd == CMD_W'(C_START_RD));
    assign is_pop       = upd_q && (cmd == CMD_W'(C_POP));
    assign is_soft      = upd_q && (cmd == CMD_W'(C_SOFT_RST));
    assign is_other     = upd_q && !(is_set_addr || is_set_be ||
                          is_set_burst || is_sel_addr || is_sel_be ||
                          is_sel_burst || is_sel_rd || is_push ||
                          is_start || is_pop || is_soft);

    assign busy      = st[ST_WBUSY] || st[ST_RBUSY];
    assign burst_bad = (burst_val == '0) || (burst_val > DEPTH);
    assign wr_next   = wr_idx + NW'(1);
    // A push in W_FILL is only taken if it does not overrun the burst
    assign push_ok   = (state == S_IDLE) ||
                       ((state == S_W_FILL) && (wr_next != burst_n));

    always_ff @(posedge JTCK) begin
        if (!n_reset || is_soft) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            push_q  <= '0;
            shadow  <= '0;
            be_q    <= 4'hF;
            burst_n <= '0;
            wr_idx  <= '0;
            st      <= '0;
`ifdef JTAG_BURST_READ_EN
            rd_idx  <= '0;
            rd_data <= '0;
`endif
        end else begin
            if (is_set_addr) begin
                if (busy) st[ST_ILLEGAL] <= 1'b1;
                else begin
                    addr_q      <= payload;
                    st[ST_ADDR] <= 1'b1;
                end
            end
            if (is_set_be) begin
                if (busy) st[ST_ILLEGAL] <= 1'b1;
                else begin
                    be_q      <= payload[3:0];
                    st[ST_BE] <= 1'b1;
                end
            end
            if (is_set_burst) begin
                if (busy || burst_bad) st[ST_ILLEGAL] <= 1'b1;
                else begin
                    burst_n      <= burst_val;
                    st[ST_BURST] <= 1'b1;
                end
            end

            unique case (1'b1)
                is_sel_addr:  shadow <= addr_q;
                is_sel_be:    shadow <= DATA_W'(be_q);
                is_sel_burst: shadow <= DATA_W'(burst_n);
`ifdef JTAG_BURST_READ_EN
                is_sel_rd:    shadow <= rd_data;
`endif
                is_other:     shadow <= DATA_W'(st);
                default: ;
            endcase

`ifndef JTAG_BURST_READ_EN
            if (is_sel_rd || is_start || is_pop)
                st[ST_ILLEGAL] <= 1'b1;
`endif

            if (is_push) begin
                if (push_ok) begin
                    push_q       <= payload;
                    st[ST_WBUSY] <= 1'b1;
                end else begin
                    st[ST_DROP]  <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (is_push)
                        state <= S_W_FILL;
`ifdef JTAG_BURST_READ_EN
                    else if (is_start) begin
                        if (&st[ST_BURST:ST_ADDR]) begin
                            st[ST_RBUSY] <= 1'b1;
                            state        <= S_R_LAUNCH;
                        end else begin
                            st[ST_ILLEGAL] <= 1'b1;
                        end
                    end
`endif
                end
                S_W_FILL: begin
                    wr_idx <= wr_next;
                    if (wr_next == burst_n) state <= S_W_WAIT_SW;
                    else if (is_push)       state <= S_W_FILL;
                    else                    state <= S_IDLE;
                end
                S_W_WAIT_SW:
                    if (switch_ready) state <= S_W_SWITCH;
                S_W_SWITCH:
                    state <= S_W_LAUNCH;
                S_W_LAUNCH: begin
                    wr_idx       <= '0;
                    st[ST_WBUSY] <= 1'b0;
                    state        <= S_IDLE;
                end
`ifdef JTAG_BURST_READ_EN
                S_R_LAUNCH:
                    state <= S_R_WAIT_SW;
                S_R_WAIT_SW:
                    if (switch_ready) state <= S_R_SWITCH;
                S_R_SWITCH:
                    state <= S_R_ASK;
                S_R_ASK:
                    state <= S_R_STORE;
                S_R_STORE: begin
                    rd_data       <= pp_data_out;
                    st[ST_RVALID] <= 1'b1;
                    state         <= S_R_READY;
                end
                S_R_READY: begin
                    if (is_pop) begin
                        st[ST_RVALID] <= 1'b0;
                        if (rd_idx == burst_n - NW'(1)) begin
                            rd_idx       <= '0;
                            st[ST_RBUSY] <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            rd_idx <= rd_idx + NW'(1);
                            state  <= S_R_ASK;
                        end
                    end
                end
`endif
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pp_address      = '0;
        pp_write_enable = 1'b0;
        pp_data_in      = '0;
        pp_switch       = 1'b0;
        dma_address     = '0;
        dma_byte_enable = '0;
        dma_data_ready  = 1'b0;
        dma_read_ready  = 1'b0;
        case (state)
            S_W_FILL: begin
                pp_write_enable = 1'b1;
                pp_address      = {1'b0, wr_idx[BUF_AW-1:0]};
                pp_data_in      = push_q;
            end
            S_W_SWITCH:
                pp_switch = 1'b1;
            S_W_LAUNCH: begin
                dma_data_ready  = 1'b1;
                dma_address     = addr_q;
                dma_byte_enable = be_q;
            end
`ifdef JTAG_BURST_READ_EN
            S_R_LAUNCH: begin
                dma_read_ready  = 1'b1;
                dma_address     = addr_q;
                dma_byte_enable = be_q;
            end
            S_R_SWITCH:
                pp_switch = 1'b1;
            S_R_ASK:
                pp_address = {1'b0, rd_idx[BUF_AW-1:0]};
`endif
            default: ;
        endcase
    end

    assign status_out = STAT_W'(st);

endmodule

// File: tb/tb_jtag_burst_chain.sv
// Directed bench for jtag_burst_chain: write bursts, overflow, resets,
// illegal commands and (with JTAG_BURST_READ_EN) the read-back path.
module tb_jtag_burst_chain;

    logic        JTCK = 1'b0;
    logic        n_reset = 1'b0;
    logic        JTDI = 1'b0;
    logic        JSHIFT = 1'b0;
    logic        JUPDATE = 1'b0;
    logic        JCE1 = 1'b0;
    logic        JTD1;
    logic [8:0]  pp_address;
    logic        pp_write_enable;
    logic [31:0] pp_data_in;
    logic [31:0] pp_data_out = '0;
    logic        pp_switch;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic        dma_data_ready;
    logic        dma_read_ready;
    logic        switch_ready = 1'b0;
    logic [7:0]  status_out;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_burst_chain dut (
        .JTCK            (JTCK),
        .n_reset         (n_reset),
        .JTDI            (JTDI),
        .JSHIFT          (JSHIFT),
        .JUPDATE         (JUPDATE),
        .JCE1            (JCE1),
        .JTD1            (JTD1),
        .pp_address      (pp_address),
        .pp_write_enable (pp_write_enable),
        .pp_data_in      (pp_data_in),
        .pp_data_out     (pp_data_out),
        .pp_switch       (pp_switch),
        .dma_address     (dma_address),
        .dma_byte_enable (dma_byte_enable),
        .dma_data_ready  (dma_data_ready),
        .dma_read_ready  (dma_read_ready),
        .switch_ready    (switch_ready),
        .status_out      (status_out)
    );

    always #5 JTCK = ~JTCK;

    // buffer read port: one cycle latency from pp_address
    always @(posedge JTCK)
        pp_data_out <= pp_address[0] ? 32'h0000_BEEF : 32'h0000_DEAD;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one full DR scan: capture, 36 shifts (LSB first), update;
    // returns at the negedge after the decode edge
    task automatic scan(input logic [3:0] c, input logic [31:0] p,
                        output logic [35:0] cap);
        logic [35:0] w;
        w = {p, c};
        @(negedge JTCK);
        JCE1 = 1'b1;
        JSHIFT = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge JTCK);
            JSHIFT = 1'b1;
            cap[i] = JTD1;
            JTDI = w[i];
        end
        @(negedge JTCK);
        JSHIFT = 1'b0;
        JCE1 = 1'b0;
        JUPDATE = 1'b1;
        @(negedge JTCK);
        JUPDATE = 1'b0;
        @(negedge JTCK);
    endtask

    logic [35:0] cap;
    logic        seen;

    initial begin
        // power-on reset
        repeat (2) @(negedge JTCK);
        chk("rst_ctl", {pp_write_enable, pp_switch, dma_data_ready,
            dma_read_ready, dma_byte_enable, pp_address}, 0);
        chk("rst_data", {dma_address, pp_data_in}, 0);
        chk("rst_status", status_out, 8'h00);
        chk("rst_jtd1", JTD1, 1'b0);
        n_reset = 1'b1;

        // write burst N=3
        scan(4'h1, 32'h0000_1000, cap);
        scan(4'h2, 32'h0000_0003, cap);
        scan(4'h3, 32'd3, cap);
        chk("cfg_status", status_out, 8'h07);
        scan(4'h4, 32'h0, cap);
        scan(4'h0, 32'h0, cap);
        chk("addr_readback", cap, 36'h1000);
        scan(4'h8, 32'h0000_000A, cap);
        chk("wr0", {pp_write_enable, pp_address, pp_data_in},
            {1'b1, 9'd0, 32'h0000_000A});
        chk("wr0_status", status_out, 8'h0F);
        scan(4'h8, 32'h0000_000B, cap);
        chk("wr1", {pp_write_enable, pp_address, pp_data_in},
            {1'b1, 9'd1, 32'h0000_000B});
        scan(4'h8, 32'h0000_000C, cap);
        chk("wr2", {pp_write_enable, pp_address, pp_data_in},
            {1'b1, 9'd2, 32'h0000_000C});
        @(negedge JTCK);
        chk("wait_sw", {pp_write_enable, pp_switch, dma_data_ready}, 0);
        switch_ready = 1'b1;
        @(negedge JTCK);
        chk("w_switch", {pp_switch, dma_data_ready}, 2'b10);
        @(negedge JTCK);
        chk("w_launch", {pp_switch, dma_data_ready, dma_address,
            dma_byte_enable}, {1'b0, 1'b1, 32'h0000_1000, 4'h3});
        @(negedge JTCK);
        chk("w_done", {dma_data_ready, status_out}, {1'b0, 8'h07});

        // overflow: N=2, three pushes with the swap held off
        switch_ready = 1'b0;
        scan(4'h3, 32'd2, cap);
        scan(4'h8, 32'h0000_0011, cap);
        scan(4'h8, 32'h0000_0022, cap);
        chk("ovf_wr1", {pp_write_enable, pp_address}, {1'b1, 9'd1});
        scan(4'h8, 32'h0000_0033, cap);
        chk("ovf_drop", {pp_write_enable, status_out}, {1'b0, 8'h4F});
        switch_ready = 1'b1;
        repeat (4) @(negedge JTCK);
        chk("ovf_after", status_out, 8'h47);

        // reset while waiting for the swap
        switch_ready = 1'b0;
        scan(4'h8, 32'h0000_0044, cap);
        scan(4'h8, 32'h0000_0055, cap);
        @(negedge JTCK);
        n_reset = 1'b0;
        repeat (2) @(negedge JTCK);
        chk("mid_rst_ctl", {pp_write_enable, pp_switch, dma_data_ready,
            dma_read_ready, dma_byte_enable, pp_address}, 0);
        chk("mid_rst_status", status_out, 8'h00);
        n_reset = 1'b1;
        switch_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge JTCK);
            seen |= pp_switch | dma_data_ready;
        end
        chk("mid_rst_no_sw", seen, 1'b0);
        scan(4'h5, 32'h0, cap);
        scan(4'h0, 32'h0, cap);
        chk("be_reset_val", cap, 36'hF);

        // illegal commands and burst-size boundaries
        scan(4'h3, 32'd0, cap);
        chk("burst0_illegal", status_out, 8'h80);
        scan(4'hF, 32'h0, cap);
        chk("soft_rst_status", status_out, 8'h00);
        scan(4'h3, 32'd257, cap);
        chk("burst257_illegal", status_out, 8'h80);
        scan(4'h3, 32'd256, cap);
        chk("burst256_ok", status_out, 8'h84);
        scan(4'hF, 32'h0, cap);
        scan(4'h9, 32'h0, cap);
        seen = dma_read_ready;
        @(negedge JTCK);
        seen |= dma_read_ready;
        chk("start_no_addr", {seen, status_out}, {1'b0, 8'h80});

`ifdef JTAG_BURST_READ_EN
        // read burst N=2
        scan(4'hF, 32'h0, cap);
        scan(4'h1, 32'h0000_2000, cap);
        scan(4'h2, 32'h0000_000C, cap);
        scan(4'h3, 32'd2, cap);
        switch_ready = 1'b1;
        scan(4'h9, 32'h0, cap);
        chk("r_launch", {dma_read_ready, dma_address, dma_byte_enable,
            status_out}, {1'b1, 32'h0000_2000, 4'hC, 8'h17});
        @(negedge JTCK);
        chk("r_wait", {dma_read_ready, pp_switch}, 2'b00);
        @(negedge JTCK);
        chk("r_switch", pp_switch, 1'b1);
        @(negedge JTCK);
        chk("r_ask0", {pp_switch, pp_address}, {1'b0, 9'd0});
        repeat (2) @(negedge JTCK);
        chk("r_ready0", status_out, 8'h37);
        scan(4'h7, 32'h0, cap);
        scan(4'h0, 32'h0, cap);
        chk("rd_word0", cap, 36'hDEAD);
        scan(4'hA, 32'h0, cap);
        chk("r_ask1", {pp_address, status_out}, {9'd1, 8'h17});
        repeat (2) @(negedge JTCK);
        scan(4'h7, 32'h0, cap);
        scan(4'h0, 32'h0, cap);
        chk("rd_word1", cap, 36'hBEEF);
        scan(4'hA, 32'h0, cap);
        chk("r_done", status_out, 8'h07);

        // soft reset while a word is waiting
        scan(4'h9, 32'h0, cap);
        repeat (5) @(negedge JTCK);
        chk("r_ready_again", status_out, 8'h37);
        scan(4'hF, 32'h0, cap);
        chk("soft_in_read", status_out, 8'h00);
        seen = 1'b0;
        repeat (6) begin
            @(negedge JTCK);
            seen |= pp_switch | dma_read_ready;
        end
        chk("soft_no_sw", seen, 1'b0);
`else
        // read commands are rejected without the read path
        scan(4'hF, 32'h0, cap);
        scan(4'h1, 32'h0000_2000, cap);
        scan(4'h2, 32'h0000_000C, cap);
        scan(4'h3, 32'd2, cap);
        switch_ready = 1'b1;
        scan(4'h9, 32'h0, cap);
        seen = dma_read_ready;
        repeat (4) begin
            @(negedge JTCK);
            seen |= dma_read_ready | pp_switch;
        end
        chk("no_rd_start", {seen, status_out}, {1'b0, 8'h87});
        scan(4'hF, 32'h0, cap);
        scan(4'h7, 32'h0, cap);
        chk("no_rd_sel", status_out, 8'h80);
        scan(4'hF, 32'h0, cap);
        scan(4'hA, 32'h0, cap);
        chk("no_rd_pop", status_out, 8'h80);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
